// File: rtl/or_edge_counter.sv
// Registers a monitored OR-stage output, counts its rising edges per WIN-clock window
// and offers each window count over a valid/ready port. Define FALL_CNT_EN to add falling-edge counting.
module or_edge_counter #(
   parameter int CNT_W = 8,
   parameter int WIN   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_sig,
   input  logic             clr,
   output logic             level,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic             rpt_sat,
`ifdef FALL_CNT_EN
   output logic [CNT_W-1:0] rpt_fall,
`endif
   output logic             rpt_lost
);

   localparam int              WW    = $clog2(WIN);
   localparam logic [WW-1:0]    WLAST = WW'(WIN - 1);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q, state_d;
   logic             level_q, level_d;
   logic [WW-1:0]    win_q, win_d;
   logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
   logic             rise_sat_q, rise_sat_d;
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
   logic             rpt_sat_q, rpt_sat_d;
   logic             rpt_lost_q, rpt_lost_d;

   logic             rise, rise_at_max, rise_sat_tot;
   logic [CNT_W-1:0] rise_tot;
   logic             fall_sat_tot;
   logic             wend, load, loss;

   // A window end coinciding with clr is dropped entirely.
   always_comb begin
      rise         = in_sig & ~level_q;
      rise_at_max  = rise & (rise_cnt_q == CMAX);
      rise_tot     = (rise & ~rise_at_max) ? rise_cnt_q + CNT_W'(1) : rise_cnt_q;
      rise_sat_tot = rise_sat_q | rise_at_max;
      wend         = (win_q == WLAST) & ~clr;
      load         = wend & ((state_q == EMPTY) | rpt_ready);
      loss         = wend & (state_q == FULL) & ~rpt_ready;
   end

`ifdef FALL_CNT_EN
   logic             fall, fall_at_max;
   logic [CNT_W-1:0] fall_tot;
   logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
   logic             fall_sat_q, fall_sat_d;
   logic [CNT_W-1:0] rpt_fall_q, rpt_fall_d;

   always_comb begin
      fall         = ~in_sig & level_q;
      fall_at_max  = fall & (fall_cnt_q == CMAX);
      fall_tot     = (fall & ~fall_at_max) ? fall_cnt_q + CNT_W'(1) : fall_cnt_q;
      fall_sat_tot = fall_sat_q | fall_at_max;
      fall_cnt_d   = (clr | wend) ? '0 : fall_tot;
      fall_sat_d   = (clr | wend) ? 1'b0 : fall_sat_tot;
      rpt_fall_d   = load ? fall_tot : rpt_fall_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fall_cnt_q <= '0;
         fall_sat_q <= 1'b0;
         rpt_fall_q <= '0;
      end else begin
         fall_cnt_q <= fall_cnt_d;
         fall_sat_q <= fall_sat_d;
         rpt_fall_q <= rpt_fall_d;
      end
   end

   assign rpt_fall = rpt_fall_q;
`else
   assign fall_sat_tot = 1'b0;
`endif

   always_comb begin
      level_d     = in_sig;
      win_d       = (clr | (win_q == WLAST)) ? '0 : win_q + WW'(1);
      rise_cnt_d  = (clr | wend) ? '0 : rise_tot;
      rise_sat_d  = (clr | wend) ? 1'b0 : rise_sat_tot;
      rpt_count_d = load ? rise_tot : rpt_count_q;
      rpt_sat_d   = load ? (rise_sat_tot | fall_sat_tot) : rpt_sat_q;

      state_d = state_q;
      case (state_q)
         EMPTY:   if (wend) state_d = FULL;
         FULL:    if (rpt_ready & ~wend) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (clr) state_d = EMPTY;

      rpt_lost_d = rpt_lost_q;
      if (clr)                                 rpt_lost_d = 1'b0;
      else if (loss)                           rpt_lost_d = 1'b1;
      else if ((state_q == FULL) & rpt_ready)  rpt_lost_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         level_q     <= 1'b0;
         win_q       <= '0;
         rise_cnt_q  <= '0;
         rise_sat_q  <= 1'b0;
         rpt_count_q <= '0;
         rpt_sat_q   <= 1'b0;
         rpt_lost_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         win_q       <= win_d;
         rise_cnt_q  <= rise_cnt_d;
         rise_sat_q  <= rise_sat_d;
         rpt_count_q <= rpt_count_d;
         rpt_sat_q   <= rpt_sat_d;
         rpt_lost_q  <= rpt_lost_d;
      end
   end

   assign level     = level_q;
   assign rpt_valid = (state_q == FULL);
   assign rpt_count = rpt_count_q;
   assign rpt_sat   = rpt_sat_q;
   assign rpt_lost  = rpt_lost_q;

endmodule
